// File: rtl/emg_adc_capture.sv
// EMG SAR ADC receive path: deserializes each conversion, tags it with channel/frame and buffers it in a FWFT FIFO.
// Optional channel-order checker is compiled in when EMG_CAPTURE_SEQ_CHECK_EN is defined.
module emg_adc_capture #(
    parameter int NUM_CH        = 16,
    parameter int ADC_CLK_CYCLE = 13,
    parameter int RES_BITS      = 10,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                clk_ADC_EMG,
    input  logic                RESET,
    input  logic                EN_ADC_EMG,
    input  logic                START_EMG,
    input  logic [3:0]          CH_SEL_EMG,
    input  logic                DOUT_EMG,
    output logic [RES_BITS+4:0] RD_DATA,
    output logic                RD_VALID,
    input  logic                RD_READY,
    output logic [4:0]          FIFO_LEVEL,
    output logic                OVERFLOW,
    output logic                PROTO_ERR,
    output logic                SEQ_ERR
);

    localparam int CNT_W  = $clog2(ADC_CLK_CYCLE + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int WORD_W = RES_BITS + 5;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] FIRST_CNT = CNT_W'(ADC_CLK_CYCLE - RES_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ADC_CLK_CYCLE - 1);
    localparam logic [4:0]       DEPTH_LVL = 5'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_next_s;
    logic                  accept_s;
    logic                  shift_en_s;
    logic                  push_s;
    logic                  proto_set_s;
    logic [3:0]            ch_r;
    logic [RES_BITS-1:0]   shift_r;
    logic [WORD_W-1:0]     word_s;

    logic [WORD_W-1:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_next_s;
    logic [4:0]            level_r;
    logic [4:0]            level_next_s;
    logic                  pop_s;
    logic                  push_ok_s;
    logic                  drop_s;
    logic                  head_valid_next_s;
    logic [WORD_W-1:0]     rd_data_r;
    logic                  rd_valid_r;
    logic                  overflow_r;
    logic                  proto_err_r;

    // Conversion window tracking: decides capture, shift and FIFO-write events
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        shift_en_s   = 1'b0;
        push_s       = 1'b0;
        proto_set_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (START_EMG && EN_ADC_EMG) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_CONV;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (!EN_ADC_EMG) begin
                    proto_set_s  = 1'b1;
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end else begin
                    if (START_EMG) begin
                        proto_set_s = 1'b1;
                    end else begin
                        proto_set_s = 1'b0;
                    end
                    if (cnt_r >= FIRST_CNT) begin
                        shift_en_s = 1'b1;
                    end else begin
                        shift_en_s = 1'b0;
                    end
                    // Final bit goes straight into the written word, so the FSM is free again next cycle
                    if (cnt_r == LAST_CNT) begin
                        push_s       = 1'b1;
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = '0;
            end
        endcase
    end

    // State and cycle counter registers
    always_ff @(posedge clk_ADC_EMG or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Channel latch and MSB-first result shift register
    always_ff @(posedge clk_ADC_EMG or posedge RESET) begin
        if (RESET) begin
            ch_r    <= 4'd0;
            shift_r <= '0;
        end else if (accept_s) begin
            ch_r    <= CH_SEL_EMG;
            shift_r <= '0;
        end else if (shift_en_s) begin
            shift_r <= {shift_r[RES_BITS-2:0], DOUT_EMG};
        end
    end

    assign word_s = {(ch_r == 4'd0), ch_r, shift_r[RES_BITS-2:0], DOUT_EMG};

    // FIFO push/pop arbitration and next occupancy
    always_comb begin
        pop_s     = rd_valid_r & RD_READY;
        push_ok_s = 1'b0;
        drop_s    = 1'b0;
        if (push_s) begin
            if ((level_r == DEPTH_LVL) && !pop_s) begin
                drop_s = 1'b1;
            end else begin
                push_ok_s = 1'b1;
            end
        end else begin
            push_ok_s = 1'b0;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        level_next_s = level_r + {4'd0, push_ok_s} - {4'd0, pop_s};
        // Head reflects only words stored before this edge, giving the one-cycle write-to-visible latency
        head_valid_next_s = ((level_r - {4'd0, pop_s}) != 5'd0);
    end

    // FIFO storage
    always_ff @(posedge clk_ADC_EMG) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= word_s;
        end
    end

    // FIFO pointers, occupancy and registered head word
    always_ff @(posedge clk_ADC_EMG or posedge RESET) begin
        if (RESET) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= 5'd0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            level_r    <= level_next_s;
            rd_valid_r <= head_valid_next_s;
            if (head_valid_next_s) begin
                rd_data_r <= mem_r[rd_ptr_next_s];
            end
        end
    end

    // Sticky error flags
    always_ff @(posedge clk_ADC_EMG or posedge RESET) begin
        if (RESET) begin
            overflow_r  <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | drop_s;
            proto_err_r <= proto_err_r | proto_set_s;
        end
    end

`ifdef EMG_CAPTURE_SEQ_CHECK_EN
    logic [3:0] exp_ch_r;
    logic       first_r;
    logic       seq_err_r;
    logic       seq_bad_s;
    logic [3:0] exp_next_s;

    // Channel-order comparison for an accepted start
    always_comb begin
        exp_next_s = 4'(({1'b0, CH_SEL_EMG} + 5'd1) % 5'(NUM_CH));
        if ({1'b0, CH_SEL_EMG} >= 5'(NUM_CH)) begin
            seq_bad_s = 1'b1;
        end else if (!first_r && (CH_SEL_EMG != exp_ch_r)) begin
            seq_bad_s = 1'b1;
        end else begin
            seq_bad_s = 1'b0;
        end
    end

    // Expected-channel tracker; resynchronizes to whatever channel was received
    always_ff @(posedge clk_ADC_EMG or posedge RESET) begin
        if (RESET) begin
            exp_ch_r  <= 4'd0;
            first_r   <= 1'b1;
            seq_err_r <= 1'b0;
        end else if (accept_s) begin
            exp_ch_r  <= exp_next_s;
            first_r   <= 1'b0;
            seq_err_r <= seq_err_r | seq_bad_s;
        end
    end

    assign SEQ_ERR = seq_err_r;
`else
    assign SEQ_ERR = 1'b0;
`endif

    assign RD_DATA    = rd_data_r;
    assign RD_VALID   = rd_valid_r;
    assign FIFO_LEVEL = level_r;
    assign OVERFLOW   = overflow_r;
    assign PROTO_ERR  = proto_err_r;

endmodule
